cpu_step_ctrl: RTL

//   Execution-clock controller for the MIPS core on the FPGA board. Consumes debounced

---
 rtl/cpu_step_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: HALT/STEP/RUN clock-enable controller for the MIPS core, with step counter.
// Optional breakpoint-on-PC halt (BRK mode) is compiled in with macro BREAKPOINT_EN.
module cpu_step_ctrl #(
  parameter int RUN_DIV = 25_000_000,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step_i,
  input  logic             btn_run_i,
  input  logic [PC_W-1:0]  cpu_pc_i,
`ifdef BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic             bp_valid_i,
`endif
  output logic             cpu_en_o,
  output logic [1:0]       mode_o,
  output logic [CNT_W-1:0] step_count_o,
  output logic             halted_on_bp_o
);
  localparam int DW = $clog2(RUN_DIV);
  typedef enum logic [1:0] {HALT = 2'b00, STEP = 2'b01, RUN = 2'b10, BRK = 2'b11} state_e;
  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic [DW-1:0]      div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_prev_q, run_prev_q;
  logic               rise_step, rise_run, term, bp_hit;
  assign rise_step = btn_step_i & ~step_prev_q;
  assign rise_run  = btn_run_i & ~run_prev_q;
  assign term      = div_q == DW'(RUN_DIV - 1);
`ifdef BREAKPOINT_EN
  assign bp_hit = bp_valid_i && cpu_pc_i == bp_addr_i;
`else
  logic unused_pc;
  assign unused_pc = ^cpu_pc_i;
  assign bp_hit    = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    div_d   = div_q;
    case (state_q)
      HALT, BRK: begin
        if (rise_run) begin
          state_d = RUN;
          div_d   = '0;
        end else if (rise_step) begin
          state_d = STEP;
          en_d    = 1'b1;
        end
      end
      STEP: state_d = HALT;
      RUN: begin
        // a run-button edge halts even on a terminal-count edge
        if (rise_run) begin
          state_d = HALT;
          div_d   = '0;
        end else if (!term) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d   = '0;
          state_d = bp_hit ? BRK : RUN;
          en_d    = !bp_hit;
        end
      end
      default: state_d = HALT;
    endcase
    cnt_d = cnt_q + CNT_W'(en_d);
  end
  // prev flags reset high so a button held through reset yields no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HALT;
      en_q        <= 1'b0;
      div_q       <= '0;
      cnt_q       <= '0;
      step_prev_q <= 1'b1;
      run_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      step_prev_q <= btn_step_i;
      run_prev_q  <= btn_run_i;
    end
  end
  assign cpu_en_o       = en_q;
  assign mode_o         = state_q;
  assign step_count_o   = cnt_q;
  assign halted_on_bp_o = state_q == BRK;
endmodule
